// File: rtl/sonar_pkg.sv
// Shared sonar definitions: transmit FSM states and carrier timing helpers, so the
// emitted frequency has a single source for both the transmit and receive chains.
package sonar_pkg;

  typedef enum logic [1:0] {IDLE, BURST, RINGDOWN, LISTEN} tx_state_t;

  function automatic int half_period(input int clk_freq, input int emitted_freq);
    return clk_freq / (2 * emitted_freq);
  endfunction

  function automatic int burst_len(input int half_per, input int burst_cycles);
    return 2 * burst_cycles * half_per;
  endfunction

endpackage

// File: rtl/carrier_tick_gen.sv
// Half-period divider: tick_out is high on the last clock of every carrier half period
// while enabled; clr_in restarts the phase so the next enabled cycle is phase 0.
module carrier_tick_gen #(
  parameter int HALF_PERIOD = 5
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic en_in,
  input  logic clr_in,
  output logic tick_out
);

  localparam int DW = (HALF_PERIOD > 2) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [DW-1:0] LAST = DW'(HALF_PERIOD - 1);

  logic [DW-1:0] div_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      div_q <= '0;
    end else if (clr_in) begin
      div_q <= '0;
    end else if (en_in) begin
      div_q <= (div_q == LAST) ? '0 : div_q + 1'b1;
    end
  end

  assign tick_out = en_in && !clr_in && (div_q == LAST);

endmodule

// File: rtl/ultrasonic_burst_tx.sv
// Sonar transmit sequencer: gated carrier burst, ringdown blanking, listen window,
// and time-of-flight capture (cycles from burst start to first echo) or timeout.
module ultrasonic_burst_tx
  import sonar_pkg::*;
#(
  parameter int CLK_FREQ          = 100_000_000,
  parameter int EMITTED_FREQUENCY = 40000,
  parameter int BURST_CYCLES      = 8,
  parameter int DEAD_CYCLES       = 50000,
  parameter int MAX_TOF_CYCLES    = 2_000_000,
  parameter int TOF_WIDTH         = 24
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  input  logic                 abort_in,
  input  logic                 echo_in,
  output logic                 tx_out,
  output logic                 tx_n_out,
  output logic                 listen_out,
  output logic                 busy_out,
  output logic [TOF_WIDTH-1:0] tof_out,
  output logic                 tof_valid_out,
  output logic                 timeout_out,
  output tx_state_t            state_out
);

  localparam int HALF_PERIOD = half_period(CLK_FREQ, EMITTED_FREQUENCY);
  localparam int BURST_LEN   = burst_len(HALF_PERIOD, BURST_CYCLES);

  if (HALF_PERIOD < 2) begin : g_bad_half_period
    $error("HALF_PERIOD must be at least 2");
  end
  if (MAX_TOF_CYCLES <= BURST_LEN + DEAD_CYCLES) begin : g_bad_max_tof
    $error("MAX_TOF_CYCLES must exceed BURST_LEN + DEAD_CYCLES");
  end
  if ((64'd1 << TOF_WIDTH) <= 64'(MAX_TOF_CYCLES)) begin : g_bad_tof_width
    $error("TOF_WIDTH too narrow for MAX_TOF_CYCLES");
  end

  // Transitions fire on the last cycle of each phase, so compare against boundary-1.
  localparam logic [TOF_WIDTH-1:0] BURST_END  = TOF_WIDTH'(BURST_LEN - 1);
  localparam logic [TOF_WIDTH-1:0] DEAD_END   = TOF_WIDTH'(BURST_LEN + DEAD_CYCLES - 1);
  localparam logic [TOF_WIDTH-1:0] LISTEN_END = TOF_WIDTH'(MAX_TOF_CYCLES - 1);

  tx_state_t            state_q;
  logic [TOF_WIDTH-1:0] cnt_q, cnt_d, tof_q;
  logic                 tx_q, tx_n_q, listen_q, busy_q, tof_valid_q, timeout_q;
  logic                 tick;

  assign cnt_d = cnt_q + 1'b1;

  carrier_tick_gen #(.HALF_PERIOD(HALF_PERIOD)) u_tick (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .en_in    (state_q == BURST && !abort_in),
    .clr_in   (state_q != BURST),
    .tick_out (tick)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tof_q       <= '0;
      tx_q        <= 1'b0;
      tx_n_q      <= 1'b0;
      listen_q    <= 1'b0;
      busy_q      <= 1'b0;
      tof_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      tof_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      if (abort_in) begin
        state_q  <= IDLE;
        cnt_q    <= '0;
        tx_q     <= 1'b0;
        tx_n_q   <= 1'b0;
        listen_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_in) begin
              state_q <= BURST;
              cnt_q   <= '0;
              tx_q    <= 1'b1;
              tx_n_q  <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
          BURST: begin
            cnt_q <= cnt_d;
            if (cnt_q == BURST_END) begin
              state_q <= RINGDOWN;
              tx_q    <= 1'b0;
              tx_n_q  <= 1'b0;
            end else if (tick) begin
              tx_q   <= ~tx_q;
              tx_n_q <= tx_q;
            end
          end
          RINGDOWN: begin
            cnt_q <= cnt_d;
            if (cnt_q == DEAD_END) begin
              state_q  <= LISTEN;
              listen_q <= 1'b1;
            end
          end
          LISTEN: begin
            cnt_q <= cnt_d;
            // Echo on the final window cycle still counts as a hit.
            if (echo_in || cnt_q == LISTEN_END) begin
              state_q     <= IDLE;
              cnt_q       <= '0;
              listen_q    <= 1'b0;
              busy_q      <= 1'b0;
              tof_valid_q <= echo_in;
              timeout_q   <= !echo_in;
              if (echo_in) tof_q <= cnt_q;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign tx_out        = tx_q;
  assign tx_n_out      = tx_n_q;
  assign listen_out    = listen_q;
  assign busy_out      = busy_q;
  assign tof_out       = tof_q;
  assign tof_valid_out = tof_valid_q;
  assign timeout_out   = timeout_q;
  assign state_out     = state_q;

endmodule

// File: tb/tb_ultrasonic_burst_tx.sv
// Directed bench for ultrasonic_burst_tx with small timing parameters
// (HALF_PERIOD=5, BURST_LEN=20, listen opens at 30, timeout after cnt 99).
module tb_ultrasonic_burst_tx;
  import sonar_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, abort = 1'b0, echo = 1'b0;
  logic       tx, tx_n, listen, busy, tof_valid, timeout;
  logic [7:0] tof;
  tx_state_t  state;

  int checks = 0;
  int failures = 0;
  int cnt_now = 0;

  ultrasonic_burst_tx #(
    .CLK_FREQ(1_000_000), .EMITTED_FREQUENCY(100_000), .BURST_CYCLES(2),
    .DEAD_CYCLES(10), .MAX_TOF_CYCLES(100), .TOF_WIDTH(8)
  ) dut (
    .clk_in(clk), .rst_in(rst_n), .start_in(start), .abort_in(abort), .echo_in(echo),
    .tx_out(tx), .tx_n_out(tx_n), .listen_out(listen), .busy_out(busy),
    .tof_out(tof), .tof_valid_out(tof_valid), .timeout_out(timeout), .state_out(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample and drive 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    cnt_now++;
  endtask

  task automatic fire();
    start = 1'b1;
    step();
    start = 1'b0;
    cnt_now = 0;
  endtask

  task automatic run_to(input int target);
    while (cnt_now < target) step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tx"}, tx, 0);
    chk({tag, "_tx_n"}, tx_n, 0);
    chk({tag, "_listen"}, listen, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_tof"}, tof, 0);
    chk({tag, "_valid"}, tof_valid, 0);
    chk({tag, "_timeout"}, timeout, 0);
  endtask

  initial begin
    int stray;
    // Reset state
    #12;
    chk_all_zero("reset");
    chk("reset_state", state, IDLE);
    rst_n = 1'b1;
    step();

    // 1: asynchronous reset in the middle of a burst
    fire();
    run_to(7);
    chk("mid_burst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    #2;
    rst_n = 1'b1;
    step();
    chk("post_rst_state", state, IDLE);
    chk("post_rst_tof", tof, 0);

    // 2 + 3: carrier waveform, ringdown echoes ignored, echo at 42 measured
    fire();
    for (int k = 0; k < 20; k++) begin
      run_to(k);
      echo = (k == 12);
      chk($sformatf("tx_c%0d", k), tx, ((k / 5) % 2 == 0) ? 1 : 0);
      chk($sformatf("tx_n_c%0d", k), tx_n, ((k / 5) % 2 == 0) ? 0 : 1);
    end
    run_to(20);
    echo = 1'b0;
    chk("burst_end_tx", tx, 0);
    chk("burst_end_tx_n", tx_n, 0);
    chk("ringdown_state", state, RINGDOWN);
    run_to(25);
    echo = 1'b1;
    step();
    echo = 1'b0;
    chk("ringdown_echo_ignored", tof_valid, 0);
    chk("ringdown_still_busy", busy, 1);
    run_to(29);
    chk("listen_c29", listen, 0);
    step();
    chk("listen_c30", listen, 1);
    run_to(42);
    echo = 1'b1;
    step();
    echo = 1'b0;
    chk("tof_42", tof, 42);
    chk("tof_valid_pulse", tof_valid, 1);
    chk("tof_busy_off", busy, 0);
    chk("tof_listen_off", listen, 0);
    step();
    chk("tof_valid_one_cycle", tof_valid, 0);
    chk("tof_hold", tof, 42);

    // 4: no echo -> timeout, previous tof kept
    fire();
    run_to(30);
    chk("to_listen_c30", listen, 1);
    run_to(99);
    chk("to_listen_c99", listen, 1);
    chk("to_no_early_timeout", timeout, 0);
    step();
    chk("timeout_pulse", timeout, 1);
    chk("timeout_tof_kept", tof, 42);
    chk("timeout_no_valid", tof_valid, 0);
    chk("timeout_listen_off", listen, 0);
    chk("timeout_idle", state, IDLE);
    step();
    chk("timeout_one_cycle", timeout, 0);

    // 5: start during burst ignored, abort at cnt 3
    fire();
    run_to(1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_ignored_cnt2_tx", tx, 1);
    run_to(3);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_state", state, IDLE);
    chk("abort_tx", tx, 0);
    chk("abort_tx_n", tx_n, 0);
    chk("abort_busy", busy, 0);
    stray = 0;
    for (int i = 0; i < 120; i++) begin
      step();
      if (tof_valid || timeout || tx || tx_n || busy) stray++;
    end
    chk("abort_no_activity", stray, 0);
    chk("abort_tof_kept", tof, 42);
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("start_with_abort_ignored", busy, 0);

    // 6: echo on last listen cycle wins; back-to-back start on tof_valid cycle
    fire();
    run_to(99);
    echo = 1'b1;
    step();
    echo = 1'b0;
    chk("edge_tof_99", tof, 99);
    chk("edge_valid", tof_valid, 1);
    chk("edge_no_timeout", timeout, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("b2b_state", state, BURST);
    chk("b2b_tx", tx, 1);
    chk("b2b_busy", busy, 1);
    chk("b2b_no_timeout", timeout, 0);
    chk("b2b_valid_cleared", tof_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
